// File: rtl/dual_pointer_fifo_pkg.sv
// Shared widths and types for the dual-pointer byte FIFO.
package dual_pointer_fifo_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage : dual_pointer_fifo_pkg

// File: rtl/fifo_ptr_counter.sv
// Wrap-bit pointer counter: synchronous clear beats increment.
module fifo_ptr_counter
  import dual_pointer_fifo_pkg::*;
(
  input  logic Clk,
  input  logic clr,
  input  logic inc,
  output ptr_t cnt
);

  // Pointer register, rolls over modulo 2**PTR_W
  always_ff @(posedge Clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + PTR_W'(1);
    end
  end

endmodule : fifo_ptr_counter

// File: rtl/dual_pointer_fifo.sv
// 16x8 FIFO on a shared tri-state byte bus, with exported read/write pointers.
module dual_pointer_fifo
  import dual_pointer_fifo_pkg::*;
(
  input  logic              Clk,
  input  logic              Load,
  input  logic              E,
  input  logic              RW,
  input  logic              RW1,
  input  logic              D,
  inout  wire  [DATA_W-1:0] IO,
  output ptr_t              front,
  output ptr_t              back,
  output logic              Empty,
  output logic              Full
);

  data_t mem [DEPTH];
  data_t dout_q;
  logic  clr_c;
  logic  wr_acc_c;
  logic  rd_acc_c;

  // Reset and flush both zero the pointers and block any access that cycle
  assign clr_c    = Load | D;
  assign wr_acc_c = ~clr_c & E &  RW & ~Full;
  assign rd_acc_c = ~clr_c & E & ~RW & ~Empty;

  // Read pointer
  fifo_ptr_counter u_front (
    .Clk (Clk),
    .clr (clr_c),
    .inc (rd_acc_c),
    .cnt (front)
  );

  // Write pointer
  fifo_ptr_counter u_back (
    .Clk (Clk),
    .clr (clr_c),
    .inc (wr_acc_c),
    .cnt (back)
  );

  // Flags: equal pointers are empty, differing only in wrap bit is full
  assign Empty = (front == back);
  assign Full  = (front[ADDR_W-1:0] == back[ADDR_W-1:0]) &&
                 (front[PTR_W-1] != back[PTR_W-1]);

  // Storage write from the bus
  always_ff @(posedge Clk) begin
    if (wr_acc_c) begin
      mem[back[ADDR_W-1:0]] <= IO;
    end
  end

  // Output data register; a flush leaves it untouched
  always_ff @(posedge Clk) begin
    if (Load) begin
      dout_q <= '0;
    end else if (rd_acc_c) begin
      dout_q <= mem[front[ADDR_W-1:0]];
    end
  end

  // Drive the bus only in read direction with drive enabled
  assign IO = (!RW && !RW1) ? dout_q : {DATA_W{1'bz}};

endmodule : dual_pointer_fifo

// File: tb/tb_dual_pointer_fifo.sv
// Directed scoreboard bench for dual_pointer_fifo.
module tb_dual_pointer_fifo;

  logic       clk = 1'b0;
  logic       load, e, rw, rw1, d;
  logic       tb_drv;
  logic [7:0] tb_data;
  wire  [7:0] io_bus;
  logic [4:0] front, back;
  logic       empty, full;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0] exp_q [$];
  logic [7:0] exp_dout;
  logic [4:0] m_front, m_back;
  int         m_cnt;

  always #5 clk = ~clk;

  // Bench drives the bus in write direction; a released bus reads as 0
  assign io_bus = tb_drv ? tb_data : 8'hzz;
  for (genvar gi = 0; gi < 8; gi++) begin : g_pd
    pulldown (io_bus[gi]);
  end

  dual_pointer_fifo dut (
    .Clk   (clk),
    .Load  (load),
    .E     (e),
    .RW    (rw),
    .RW1   (rw1),
    .D     (d),
    .IO    (io_bus),
    .front (front),
    .back  (back),
    .Empty (empty),
    .Full  (full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one clock of stimulus, advance the model, then check all outputs
  task automatic do_cycle(input logic i_load, input logic i_d, input logic i_e,
                          input logic i_rw, input logic i_rw1, input logic [7:0] wdata);
    load    = i_load;
    d       = i_d;
    e       = i_e;
    rw      = i_rw;
    rw1     = i_rw1;
    tb_drv  = i_rw;
    tb_data = wdata;

    if (i_load) begin
      m_front = '0; m_back = '0; m_cnt = 0; exp_dout = 8'h00;
      exp_q.delete();
    end else if (i_d) begin
      m_front = '0; m_back = '0; m_cnt = 0;
      exp_q.delete();
    end else if (i_e && i_rw && m_cnt < 16) begin
      exp_q.push_back(wdata);
      m_back = m_back + 5'd1;
      m_cnt++;
    end else if (i_e && !i_rw && m_cnt > 0) begin
      exp_dout = exp_q.pop_front();
      m_front  = m_front + 5'd1;
      m_cnt--;
    end

    @(posedge clk);
    #1;
    chk("front", 32'(front), 32'(m_front));
    chk("back",  32'(back),  32'(m_back));
    chk("empty", 32'(empty), 32'(m_cnt == 0));
    chk("full",  32'(full),  32'(m_cnt == 16));
    if (!i_rw && !i_rw1) begin
      chk("io_data", 32'(io_bus), 32'(exp_dout));
    end else if (!i_rw && i_rw1) begin
      chk("io_released", 32'(io_bus), 32'h0);
    end
  endtask

  initial begin
    load = 1'b1; d = 1'b0; e = 1'b0; rw = 1'b1; rw1 = 1'b1;
    tb_drv = 1'b1; tb_data = 8'h00;
    m_front = '0; m_back = '0; m_cnt = 0; exp_dout = 8'h00;

    // Reset, then idle with bus in write direction
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    chk("rst_front_lit", 32'(front), 32'h0);
    chk("rst_empty_lit", 32'(empty), 32'h1);

    // Fill with 10,12,...,40
    for (int i = 0; i < 16; i++) do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'(10 + 2 * i));
    chk("fill_back_lit", 32'(back), 32'h10);
    chk("fill_full_lit", 32'(full), 32'h1);

    // Overflow attempts 42..48 must be dropped
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'(42 + 2 * i));
    chk("ovf_back_lit", 32'(back), 32'h10);

    // Drain in order
    for (int i = 0; i < 16; i++) do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("drain_front_lit", 32'(front), 32'h10);
    chk("drain_io_lit", 32'(io_bus), 32'd40);

    // Underflow holds pointer and data, then release the bus
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("udf_io_lit", 32'(io_bus), 32'd40);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Two write-8/read-8 rounds; back wraps 31 -> 0
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'(8'h80 + 16 * r + i));
      for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    end
    chk("wrap_back_lit", 32'(back), 32'h0);

    // Partial fill then flush; data register survives the flush
    for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'(8'hC0 + i));
    do_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hEE);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("flush_io_lit", 32'(io_bus), 32'h97);

    // Reset during a write suppresses it and clears the data register
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'(8'hD0 + i));
    do_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h77);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("post_rst_io_lit", 32'(io_bus), 32'h55);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_dual_pointer_fifo

// File: doc/dual_pointer_fifo.md
Name: dual_pointer_fifo

Overview:
- Synchronous 16-entry x 8-bit FIFO with a single bidirectional 8-bit data bus IO.
- Two independent 5-bit pointer counters (front = read, back = write) are exported for debug and observation, along with Empty and Full flags.
- Sits between a shared tri-state byte bus and a consumer/producer that time-multiplexes the bus via RW.

Parameters:
- DATA_W, 8, width of IO and storage words.
- ADDR_W, 4, storage address width; depth = 2**ADDR_W = 16.
- PTR_W, ADDR_W+1 = 5, pointer width; MSB is the wrap bit.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Load  in  1  reset; synchronous, active-high.
- E  in  1  enable; no operation occurs when 0.
- RW  in  1  direction: 1 = write (external agent drives IO), 0 = read (FIFO may drive IO).
- RW1  in  1  read-bus drive control, active-low; the FIFO drives IO only when RW=0 and RW1=0.
- D  in  1  synchronous flush, active-high.
- IO  inout  8  data bus: input when RW=1; output when RW=0 and RW1=0; high-Z otherwise.
- front  out  5  read pointer {wrap, addr}.
- back  out  5  write pointer {wrap, addr}.
- Empty  out  1  high when FIFO holds 0 entries.
- Full  out  1  high when FIFO holds 16 entries.

Behaviour:
- Reset (Load=1 at posedge):
  - front=0, back=0, output data register=0.
  - Empty=1, Full=0.
  - Storage contents are don't-care.
  - Load has priority over D, E and RW.
- Flush (D=1, Load=0, at posedge):
  - front=0, back=0; data register holds its value.
  - Flush has priority over E and RW.
- Write (E=1, RW=1, Full=0, at posedge):
  - mem[back[3:0]] <= IO; back <= back+1 (modulo 32).
- Read (E=1, RW=0, Empty=0, at posedge):
  - data register <= mem[front[3:0]]; front <= front+1 (modulo 32).
  - Latency: data appears on IO one cycle after the read edge, and only while RW=0 and RW1=0.
- Ignored operations:
  - Write while Full: no pointer or memory change.
  - Read while Empty: no pointer change; data register holds its value.
  - E=0: no pointer, memory or register change.
- Flags (combinational from the registered pointers):
  - Empty = (front == back).
  - Full = (front[3:0] == back[3:0]) && (front[4] != back[4]).
  - Both update in the cycle after the causing edge.
- Simultaneous read and write is impossible, because RW selects exactly one operation per cycle.
- Wrap-around: pointers roll 31 -> 0; the address uses the low 4 bits.
- IO tri-state:
  - IO = (RW==0 && RW1==0) ? data register : 8'hzz.
  - The FIFO never drives IO while RW=1.
- Reset mid-operation: Load overrides any pending read or write in the same cycle.

Decomposition:
- Shared package: DATA_W, ADDR_W, PTR_W constants and a ptr_t typedef (logic [PTR_W-1:0]).
- One natural sub-module, fifo_ptr_counter: PTR_W-bit synchronous counter with clear (Load|D) and increment-enable.
  - Instantiated twice: once for front (enable = read accept), once for back (enable = write accept).
- Storage array, flag logic and tri-state driver live in the top level.

Test Plan:
- Reset: Load=1 for one edge, then Load=0 -> front=0, back=0, Empty=1, Full=0, IO=high-Z while RW=1.
- Fill: E=1, RW=1, write 10,12,...,40 on 16 consecutive edges -> back=5'b10000, front=0, Full=1, Empty=0.
- Overflow: 4 more writes (42..48) while Full -> back stays 5'b10000, memory unchanged, Full stays 1.
- Drain: RW=0, RW1=0, 16 read edges -> IO shows 10,12,...,40 in order, each one cycle after its edge; front=5'b10000, Empty=1.
- Underflow and tri-state: further reads while Empty -> front unchanged, IO holds 40; RW1=1 -> IO=high-Z.
- Wrap and flush:
  - Write 8 / read 8 twice (pointers pass 31 -> 0) -> data order preserved, flags correct.
  - Mid-fill D=1 -> front=back=0, Empty=1.
  - Load=1 during a write -> write suppressed.
